// File: rtl/prog_timing_gen.sv
// prog_timing_gen: multi-channel programmable timing generator.
// Each channel divides clk by a programmable period P and produces a clock
// that is high for H cycles, plus a one-cycle tick at the start of every period.
// Optional reset-pulse sequencer, enabled by defining TGEN_RST_SEQ_EN.
// Without the macro, rst_out and rst_busy are tied low and rst_start is unused.
//
// Channel FSM
//   state    | meaning
//   CH_IDLE  | stopped, outputs low, active config follows shadow
//   CH_RUN   | counting 0..Pe-1, shadow config loaded at each wrap
//
// Sequencer FSM (TGEN_RST_SEQ_EN)
//   state     | meaning
//   SQ_IDLE   | waiting for rst_start
//   SQ_DELAY  | counting RST_DLY cycles before asserting rst_out
//   SQ_ASSERT | rst_out high for RST_W cycles
module prog_timing_gen #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int RST_DLY  = 2,
  parameter int RST_W    = 1
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                               cfg_period,
  input  logic [CNT_W-1:0]                               cfg_high,
  input  logic [CHANNELS-1:0]                            ch_en,
  input  logic                                           rst_start,
  output logic [CHANNELS-1:0]                            div_clk,
  output logic [CHANNELS-1:0]                            tick,
  output logic                                           rst_out,
  output logic                                           rst_busy
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {CH_IDLE, CH_RUN} ch_state_t;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    ch_state_t        r_state;
    ch_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_per;
    logic [CNT_W-1:0] r_hi;
    logic [CNT_W-1:0] r_sh_per;
    logic [CNT_W-1:0] r_sh_hi;
    logic [CNT_W-1:0] w_per_nxt;
    logic [CNT_W-1:0] w_hi_nxt;
    logic [CNT_W-1:0] w_sh_per_nxt;
    logic [CNT_W-1:0] w_sh_hi_nxt;
    logic [CNT_W-1:0] w_pe;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_wr;
    logic             w_wrap;
    logic             r_div;
    logic             r_tick;
    logic             w_div_nxt;
    logic             w_tick_nxt;

    // Out-of-range channel numbers match no decoder and are dropped.
    assign w_wr      = cfg_we && (cfg_ch == CH_W'(g));
    assign w_pe      = (r_per == '0) ? CNT_W'(1) : r_per;
    assign w_wrap    = (r_cnt == (w_pe - CNT_W'(1)));
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // Next-state, counter, config-transfer and output decode for one channel.
    always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_per_nxt    = r_per;
      w_hi_nxt     = r_hi;
      w_sh_per_nxt = w_wr ? cfg_period : r_sh_per;
      w_sh_hi_nxt  = w_wr ? cfg_high : r_sh_hi;
      w_div_nxt    = 1'b0;
      w_tick_nxt   = 1'b0;
      case (r_state)
        CH_IDLE: begin
          // A stopped channel has no period to protect, so writes land at once.
          w_per_nxt = w_sh_per_nxt;
          w_hi_nxt  = w_sh_hi_nxt;
          w_cnt_nxt = '0;
          if (ch_en[g]) begin
            w_state_nxt = CH_RUN;
            w_tick_nxt  = 1'b1;
            w_div_nxt   = (w_sh_hi_nxt != '0);
          end
        end
        CH_RUN: begin
          if (!ch_en[g]) begin
            w_state_nxt = CH_IDLE;
            w_cnt_nxt   = '0;
            w_per_nxt   = w_sh_per_nxt;
            w_hi_nxt    = w_sh_hi_nxt;
          end else if (w_wrap) begin
            // Period boundary: pick up the shadow, including a same-cycle write.
            w_cnt_nxt  = '0;
            w_per_nxt  = w_sh_per_nxt;
            w_hi_nxt   = w_sh_hi_nxt;
            w_tick_nxt = 1'b1;
            w_div_nxt  = (w_sh_hi_nxt != '0);
          end else begin
            w_cnt_nxt = w_cnt_inc;
            w_div_nxt = (w_cnt_inc < r_hi);
          end
        end
        default: begin
          w_state_nxt = CH_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    // Channel state, counter, config and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state  <= CH_IDLE;
        r_cnt    <= '0;
        r_per    <= CNT_W'(2);
        r_hi     <= CNT_W'(1);
        r_sh_per <= CNT_W'(2);
        r_sh_hi  <= CNT_W'(1);
        r_div    <= 1'b0;
        r_tick   <= 1'b0;
      end else begin
        r_state  <= w_state_nxt;
        r_cnt    <= w_cnt_nxt;
        r_per    <= w_per_nxt;
        r_hi     <= w_hi_nxt;
        r_sh_per <= w_sh_per_nxt;
        r_sh_hi  <= w_sh_hi_nxt;
        r_div    <= w_div_nxt;
        r_tick   <= w_tick_nxt;
      end
    end

    assign div_clk[g] = r_div;
    assign tick[g]    = r_tick;
  end

`ifdef TGEN_RST_SEQ_EN
  localparam int SQ_MAX = (RST_DLY > RST_W) ? RST_DLY : RST_W;
  localparam int TMR_W  = $clog2(SQ_MAX + 1);

  typedef enum logic [1:0] {SQ_IDLE, SQ_DELAY, SQ_ASSERT} sq_state_t;

  sq_state_t        r_sq_state;
  sq_state_t        w_sq_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_nxt;
  logic             r_rst_out;
  logic             r_rst_busy;

  // Sequencer next state; the down-counter holds cycles left in the phase.
  always_comb begin
    w_sq_nxt  = r_sq_state;
    w_tmr_nxt = r_tmr;
    case (r_sq_state)
      SQ_IDLE: begin
        if (rst_start) begin
          w_sq_nxt  = SQ_DELAY;
          w_tmr_nxt = TMR_W'(RST_DLY - 1);
        end
      end
      SQ_DELAY: begin
        if (r_tmr == '0) begin
          w_sq_nxt  = SQ_ASSERT;
          w_tmr_nxt = TMR_W'(RST_W - 1);
        end else begin
          w_tmr_nxt = r_tmr - TMR_W'(1);
        end
      end
      SQ_ASSERT: begin
        if (r_tmr == '0) begin
          w_sq_nxt  = SQ_IDLE;
          w_tmr_nxt = '0;
        end else begin
          w_tmr_nxt = r_tmr - TMR_W'(1);
        end
      end
      default: begin
        w_sq_nxt  = SQ_IDLE;
        w_tmr_nxt = '0;
      end
    endcase
  end

  // Sequencer state, timer and registered pulse/busy outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sq_state <= SQ_IDLE;
      r_tmr      <= '0;
      r_rst_out  <= 1'b0;
      r_rst_busy <= 1'b0;
    end else begin
      r_sq_state <= w_sq_nxt;
      r_tmr      <= w_tmr_nxt;
      r_rst_out  <= (w_sq_nxt == SQ_ASSERT);
      r_rst_busy <= (w_sq_nxt != SQ_IDLE);
    end
  end

  assign rst_out  = r_rst_out;
  assign rst_busy = r_rst_busy;
`else
  localparam int p_unused_seq = RST_DLY + RST_W;
  logic w_unused_rst_start;

  assign w_unused_rst_start = rst_start;
  assign rst_out            = 1'b0;
  assign rst_busy           = 1'b0;
`endif

endmodule

// File: tb/tb_prog_timing_gen.sv
// Self-checking bench for prog_timing_gen (3 channels so an out-of-range
// cfg_ch value exists; sequencer RST_DLY=2, RST_W=3).
module tb_prog_timing_gen;
  localparam int NCH = 3;

  logic           clk;
  logic           reset;
  logic           cfg_we;
  logic [1:0]     cfg_ch;
  logic [7:0]     cfg_period;
  logic [7:0]     cfg_high;
  logic [NCH-1:0] ch_en;
  logic           rst_start;
  logic [NCH-1:0] div_clk;
  logic [NCH-1:0] tick;
  logic           rst_out;
  logic           rst_busy;

  prog_timing_gen #(.CHANNELS(NCH), .CNT_W(8), .RST_DLY(2), .RST_W(3)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .ch_en(ch_en),
    .rst_start(rst_start), .div_clk(div_clk), .tick(tick),
    .rst_out(rst_out), .rst_busy(rst_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] div;
    logic [NCH-1:0] tck;
    logic           ro;
    logic           rb;
    string          name;
  } exp_t;

  typedef struct {
    int          ch;
    int          p;
    int          h;
    int          n;
    logic [15:0] dpat;
    logic [15:0] tpat;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_on[NCH];
  int   m_i[NCH];
  int   m_p[NCH];
  int   m_h[NCH];
  logic e_ro = 1'b0;
  logic e_rb = 1'b0;

  task automatic push_and_check(input logic [NCH-1:0] d, input logic [NCH-1:0] t, input string name);
    exp_t e;
    exp_t a;
    e.div = d; e.tck = t; e.ro = e_ro; e.rb = e_rb; e.name = name;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    a = sb_q.pop_front();
    n_checks++;
    if (div_clk !== a.div || tick !== a.tck || rst_out !== a.ro || rst_busy !== a.rb) begin
      n_fail++;
      $display("FAIL %s: got div_clk=%b tick=%b rst_out=%b rst_busy=%b, want div_clk=%b tick=%b rst_out=%b rst_busy=%b",
               a.name, div_clk, tick, rst_out, rst_busy, a.div, a.tck, a.ro, a.rb);
    end
  endtask

  // Expected values from the period/high-time formula for channels started from idle.
  task automatic cyc_model(input string name);
    logic [NCH-1:0] d;
    logic [NCH-1:0] t;
    d = '0; t = '0;
    for (int c = 0; c < NCH; c++) begin
      if (m_on[c] != 0) begin
        int pe;
        int k;
        pe = (m_p[c] == 0) ? 1 : m_p[c];
        k = m_i[c] % pe;
        t[c] = (k == 0);
        d[c] = (k < m_h[c]);
        m_i[c]++;
      end
    end
    push_and_check(d, t, name);
  endtask

  task automatic cyc_ch(input int ch, input logic d, input logic t, input string name);
    logic [NCH-1:0] dv;
    logic [NCH-1:0] tv;
    dv = '0; tv = '0;
    dv[ch] = d; tv[ch] = t;
    push_and_check(dv, tv, name);
  endtask

  task automatic chk_zero(input string name);
    n_checks++;
    if (div_clk !== '0 || tick !== '0 || rst_out !== 1'b0 || rst_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got div_clk=%b tick=%b rst_out=%b rst_busy=%b, want all zero",
               name, div_clk, tick, rst_out, rst_busy);
    end
  endtask

  task automatic set_en(input int ch, input logic v);
    ch_en[ch] = v;
    m_on[ch] = v ? 1 : 0;
    m_i[ch] = 0;
  endtask

  task automatic cfg_set(input int ch, input int p, input int h);
    logic [1:0] chv;
    chv = ch[1:0];
    cfg_we = 1'b1; cfg_ch = chv; cfg_period = p[7:0]; cfg_high = h[7:0];
    if (ch < NCH) begin
      m_p[ch] = p; m_h[ch] = h;
    end
  endtask

  task automatic cfg_clr();
    cfg_we = 1'b0;
  endtask

  initial begin
    // ch, P, H, cycles, div pattern (bit i = cycle i after enable), tick pattern
    vecs[0] = '{1, 5,   2, 10, 16'h0063, 16'h0021};
    vecs[1] = '{2, 4,   0,  8, 16'h0000, 16'h0011};
    vecs[2] = '{2, 4,   9,  8, 16'h00FF, 16'h0011};
    vecs[3] = '{0, 0,   1,  5, 16'h001F, 16'h001F};
    vecs[4] = '{1, 1,   0,  4, 16'h0000, 16'h000F};
    vecs[5] = '{0, 3,   1,  7, 16'h0049, 16'h0049};
    vecs[6] = '{1, 4,   4,  8, 16'h00FF, 16'h0011};
    vecs[7] = '{2, 255, 1,  4, 16'h0001, 16'h0001};
    for (int c = 0; c < NCH; c++) begin
      m_on[c] = 0; m_i[c] = 0; m_p[c] = 2; m_h[c] = 1;
    end

    reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_high = '0;
    ch_en = '0; rst_start = 1'b0;
    #1 reset = 1'b0;
    #1 chk_zero("reset state");

    // Divide-by-2 from reset defaults, async reset mid-run, restart.
    @(posedge clk);
    #3;
    reset = 1'b1;
    set_en(0, 1'b1);
    for (int i = 0; i < 3; i++) cyc_model($sformatf("div2 run%0d", i));
    reset = 1'b0;
    #1 chk_zero("async reset mid-run");
    #2 reset = 1'b1;
    m_i[0] = 0;
    for (int i = 0; i < 4; i++) cyc_model($sformatf("div2 restart%0d", i));
    set_en(0, 1'b0);
    cyc_model("div2 stop");

    // Table of single-channel configurations, each started from idle.
    for (int v = 0; v < 8; v++) begin
      cfg_set(vecs[v].ch, vecs[v].p, vecs[v].h);
      cyc_model($sformatf("tbl%0d cfg", v));
      cfg_clr();
      set_en(vecs[v].ch, 1'b1);
      for (int i = 0; i < vecs[v].n; i++)
        cyc_ch(vecs[v].ch, vecs[v].dpat[i], vecs[v].tpat[i], $sformatf("tbl%0d run%0d", v, i));
      set_en(vecs[v].ch, 1'b0);
      cyc_model($sformatf("tbl%0d stop", v));
    end

    // Reconfiguring a running channel: deferred to wrap, immediate at wrap, last write wins.
    cfg_set(2, 4, 2);
    cyc_model("recfg idle");
    cfg_clr();
    set_en(2, 1'b1);
    cyc_ch(2, 1, 1, "recfg p4 c0");
    cyc_ch(2, 1, 0, "recfg p4 c1");
    cfg_set(2, 6, 3);
    cyc_ch(2, 0, 0, "recfg p4 c2");
    cfg_clr();
    cyc_ch(2, 0, 0, "recfg p4 c3");
    cyc_ch(2, 1, 1, "recfg p6 c0");
    cyc_ch(2, 1, 0, "recfg p6 c1");
    cyc_ch(2, 1, 0, "recfg p6 c2");
    cyc_ch(2, 0, 0, "recfg p6 c3");
    cyc_ch(2, 0, 0, "recfg p6 c4");
    cyc_ch(2, 0, 0, "recfg p6 c5");
    cfg_set(2, 4, 1);
    cyc_ch(2, 1, 1, "wrapwr p4h1 c0");
    cfg_clr();
    cyc_ch(2, 0, 0, "wrapwr p4h1 c1");
    cyc_ch(2, 0, 0, "wrapwr p4h1 c2");
    cyc_ch(2, 0, 0, "wrapwr p4h1 c3");
    cyc_ch(2, 1, 1, "wrapwr p4h1 c0b");
    cfg_set(2, 6, 3);
    cyc_ch(2, 0, 0, "lastwins c1");
    cfg_set(2, 3, 2);
    cyc_ch(2, 0, 0, "lastwins c2");
    cfg_clr();
    cyc_ch(2, 0, 0, "lastwins c3");
    cyc_ch(2, 1, 1, "lastwins p3 c0");
    cyc_ch(2, 1, 0, "lastwins p3 c1");
    cyc_ch(2, 0, 0, "lastwins p3 c2");
    cyc_ch(2, 1, 1, "lastwins p3 c0b");
    set_en(2, 1'b0);
    cyc_model("recfg stop");

    // Out-of-range cfg_ch is ignored; three independent channels together.
    cfg_set(1, 5, 3);
    cyc_model("indep cfg ch1");
    cfg_set(3, 1, 0);
    cyc_model("ignore cfg_ch=3");
    cfg_clr();
    set_en(0, 1'b1); set_en(1, 1'b1); set_en(2, 1'b1);
    for (int i = 0; i < 12; i++) cyc_model($sformatf("indep run%0d", i));
    set_en(0, 1'b0); set_en(1, 1'b0); set_en(2, 1'b0);
    cyc_model("indep stop");

    // Drop ch_en at cnt=3, then raise again.
    cfg_set(0, 5, 2);
    cyc_model("drop cfg");
    cfg_clr();
    set_en(0, 1'b1);
    for (int i = 0; i < 4; i++) cyc_model($sformatf("drop run%0d", i));
    set_en(0, 1'b0);
    cyc_model("drop off");
    set_en(0, 1'b1);
    for (int i = 0; i < 6; i++) cyc_model($sformatf("drop rerun%0d", i));
    set_en(0, 1'b0);
    cyc_model("drop stop");

`ifdef TGEN_RST_SEQ_EN
    rst_start = 1'b1; e_ro = 1'b0; e_rb = 1'b1;
    cyc_model("seq delay0");
    rst_start = 1'b0;
    cyc_model("seq delay1");
    e_ro = 1'b1;
    cyc_model("seq assert0");
    cyc_model("seq assert1");
    rst_start = 1'b1;
    cyc_model("seq assert2");
    rst_start = 1'b0; e_ro = 1'b0; e_rb = 1'b0;
    cyc_model("seq done");
    cyc_model("seq ignored start");
    rst_start = 1'b1; e_rb = 1'b1;
    cyc_model("seq2 delay0");
    rst_start = 1'b0;
    cyc_model("seq2 delay1");
    e_ro = 1'b1;
    cyc_model("seq2 assert0");
    reset = 1'b0;
    #1 chk_zero("seq async reset");
    #2 reset = 1'b1;
    e_ro = 1'b0; e_rb = 1'b0;
    cyc_model("seq after reset0");
    cyc_model("seq after reset1");
`else
    rst_start = 1'b1;
    cyc_model("noseq start0");
    cyc_model("noseq start1");
    rst_start = 1'b0;
    for (int i = 0; i < 4; i++) cyc_model($sformatf("noseq idle%0d", i));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
